pic_priority_sequencer: RTL
===========================

Name: pic_priority_sequencer

Overview:
- Synchronous interrupt scheduler for the 8259A-style PIC.
- Latches IR requests into the IRR and resolves priority against the IMR and ISR, in fully nested or rotating order.
- Drives INT and runs the two-pulse INTA acknowledge sequence, then supplies the 3-bit winning level (int_vec) that the control logic combines with T7–T3.
- Owns the ISR and executes OCW2 EOI/rotate commands.

Parameters:
- NUM_IR, 8, number of interrupt request lines (fixed at 8; vectors are 3 bits).
- SPURIOUS_LVL, 7, level reported when no request is valid at first INTA.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- ir  input  8  interrupt request lines, already synchronous to clk.
- imr  input  8  interrupt mask register; 1 = masked.
- ltim  input  1  1 = level-triggered, 0 = edge-triggered.
- aeoi  input  1  automatic EOI mode.
- inta_n  input  1  CPU acknowledge, active-low, synchronous to clk.
- ocw2  input  8  OCW2 data: [7:5] = R/SL/EOI, [2:0] = L2–L0.
- ocw2_wr  input  1  one-cycle strobe; ocw2 is valid this cycle.
- int_out  output  1  interrupt request to the CPU.
- int_vec  output  3  acknowledged level.
- vec_valid  output  1  one-cycle pulse; int_vec is valid.
- first_ack  output  1  high while in ACK1.
- second_ack  output  1  high during the ACK2 cycle.
- irr  output  8  interrupt request register.
- isr  output  8  in-service register.

Behaviour:
- Reset values:
  - irr, isr, int_vec, int_out, vec_valid, first_ack, second_ack = 0.
  - lowest_prio = 7, so IR0 has highest priority.
  - rotate_aeoi = 0; state = IDLE; inta_q = 1; ir_q = 0.
- IRR update:
  - Edge mode: irr[i] sets on an ir rising edge (ir & ~ir_q). It clears when ir[i] drops, or when level i is acknowledged at ACK1.
  - Level mode: irr[i] = ir[i] every cycle, registered.
- Priority order:
  - The highest level is lowest_prio+1 mod 8, ascending with wrap-around.
  - cand = irr & ~imr; win = highest-priority cand bit.
  - Pending when cand ≠ 0 and win outranks every set isr bit. An equal or higher level in service blocks the request.
- int_out:
  - Registered; goes high the cycle after pending becomes true.
  - Cleared at the ACK1 entry cycle.
  - Re-evaluated in IDLE only.
- INTA falling edge: inta_q & ~inta_n.
- FSM transitions:
  - IDLE → ACK1 on an INTA falling edge.
    - Latch ack_lvl = win, or SPURIOUS_LVL if not pending.
    - If pending, set isr[win] and clear irr[win] in edge mode.
    - A spurious acknowledge sets no isr bit.
  - ACK1 → ACK2 on the next INTA falling edge.
    - int_vec = ack_lvl; vec_valid = 1 for one cycle; second_ack = 1.
  - ACK2 → IDLE on the following cycle.
    - If aeoi and the acknowledge was non-spurious, clear isr[ack_lvl].
    - If aeoi and rotate_aeoi are both set, lowest_prio = ack_lvl.
- INTA in other states: an INTA falling edge in ACK2 is ignored. Levels on inta_n in other states are ignored.
- OCW2 decode, when ocw2_wr; [7:5]:
  - 001: non-specific EOI; clear the highest-priority set isr bit.
  - 011: specific EOI; clear isr[L].
  - 101: rotate on non-specific EOI; clear the highest isr bit, lowest_prio = that level.
  - 111: rotate on specific EOI; clear isr[L], lowest_prio = L.
  - 110: set priority; lowest_prio = L.
  - 100: rotate_aeoi = 1.
  - 000: rotate_aeoi = 0.
  - 010: no-op.
  - An EOI with isr = 0 is a no-op; a non-specific rotate then leaves lowest_prio unchanged.
- Simultaneous events:
  - EOI is computed from the pre-cycle isr.
  - If an EOI clear and an ACK1 set hit the same bit in one cycle, the set wins.
  - If ocw2 and AEOI both write lowest_prio in the same cycle, ocw2 wins.
- Mask changes after ACK1 do not alter the latched ack_lvl.
- Reset mid-sequence returns every output and register to its reset value immediately; no vector is emitted.

Test Plan:
- Edge mode, imr = 0, pulse ir = 0x28 → int_out rises 1 cycle later.
  - INTA#1 → isr = 0x08, irr = 0x20.
  - INTA#2 → int_vec = 3 with a 1-cycle vec_valid.
  - OCW2 = 0x20 → isr = 0x00, then int_out rises again for level 5.
- Nesting: isr = 0x04 with ir2 in service; raise ir4 → int_out stays 0. Raise ir1 → int_out = 1; ack gives int_vec = 1, isr = 0x06.
- Rotation: OCW2 = 0xC4 (set priority, L = 4), ir = 0x21 in level mode → int_vec = 5. OCW2 = 0xA0 → isr[5] clears, lowest_prio = 5, next int_vec = 0.
- AEOI with rotate: aeoi = 1, OCW2 = 0x80, ir3 → after ACK2, isr = 0x00 and lowest_prio = 3.
- Spurious: raise ir6, then drop it before INTA#1 (edge mode) → int_vec = 7 and isr unchanged at 0x00.
- Reset asserted in ACK1 → all outputs 0 and state IDLE; the next INTA#2 produces no vec_valid.

Source files
------------

// File: rtl/pic_priority_sequencer.sv
// 8259A-style interrupt scheduler: IRR/ISR, nested or rotating priority,
// two-pulse INTA acknowledge and OCW2 EOI/rotate handling.
module pic_priority_sequencer #(
  parameter int NUM_IR = 8,
  parameter logic [2:0] SPURIOUS_LVL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic [7:0] imr,
  input  logic       ltim,
  input  logic       aeoi,
  input  logic       inta_n,
  input  logic [7:0] ocw2,
  input  logic       ocw2_wr,
  output logic       int_out,
  output logic [2:0] int_vec,
  output logic       vec_valid,
  output logic       first_ack,
  output logic       second_ack,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK1 = 2'd1;
  localparam logic [1:0] ACK2 = 2'd2;

  logic [1:0] state;
  logic [2:0] lowest_prio;
  logic       rotate_aeoi;
  logic       inta_q;
  logic [7:0] ir_q;
  logic [2:0] ack_lvl;
  logic       ack_real;

  // {found, level} of the highest-priority set bit, scanning from lp+1
  function automatic logic [3:0] pick(
    input logic [7:0] v,
    input logic [2:0] lp
  );
    logic [3:0] res;
    logic [2:0] l;
    res = '0;
    for (int r = 7; r >= 0; r--) begin
      l = lp + 3'd1 + 3'(r);
      if (v[l]) res = {1'b1, l};
    end
    return res;
  endfunction

  function automatic logic [2:0] rank(
    input logic [2:0] lvl,
    input logic [2:0] lp
  );
    return lvl - lp - 3'd1;
  endfunction

  logic [7:0] cand;
  logic       cand_any, isr_any, pending;
  logic [2:0] win, isr_hi;
  logic       inta_fall, ack1, ack2, done;

  assign cand = irr & ~imr;
  assign {cand_any, win} = pick(cand, lowest_prio);
  assign {isr_any, isr_hi} = pick(isr, lowest_prio);
  assign pending = cand_any &
    (~isr_any | (rank(win, lowest_prio) < rank(isr_hi, lowest_prio)));
  assign inta_fall = inta_q & ~inta_n;
  assign ack1 = (state == IDLE) & inta_fall;
  assign ack2 = (state == ACK1) & inta_fall;
  assign done = (state == ACK2);

  logic [2:0] cmd, lvl_l;
  logic [7:0] eoi_clr;
  logic       lp_we;
  logic [2:0] lp_new;
  logic       rot_new;

  assign cmd = ocw2[7:5];
  assign lvl_l = ocw2[2:0];

  always_comb begin
    eoi_clr = '0;
    lp_we = 1'b0;
    lp_new = lowest_prio;
    rot_new = rotate_aeoi;
    if (ocw2_wr) begin
      unique case (1'b1)
        (cmd == 3'b001): begin
          if (isr_any) eoi_clr[isr_hi] = 1'b1;
        end
        (cmd == 3'b011): eoi_clr[lvl_l] = 1'b1;
        (cmd == 3'b101): begin
          if (isr_any) begin
            eoi_clr[isr_hi] = 1'b1;
            lp_we = 1'b1;
            lp_new = isr_hi;
          end
        end
        (cmd == 3'b111): begin
          eoi_clr[lvl_l] = 1'b1;
          lp_we = 1'b1;
          lp_new = lvl_l;
        end
        (cmd == 3'b110): begin
          lp_we = 1'b1;
          lp_new = lvl_l;
        end
        (cmd == 3'b100): rot_new = 1'b1;
        (cmd == 3'b000): rot_new = 1'b0;
        default: ;
      endcase
    end
  end

  logic [7:0] set_mask, aeoi_clr, irr_edge, irr_n, isr_n;

  always_comb begin
    set_mask = '0;
    if (ack1 & pending) set_mask[win] = 1'b1;
    aeoi_clr = '0;
    if (done & aeoi & ack_real) aeoi_clr[ack_lvl] = 1'b1;
    irr_edge = (irr | (ir & ~ir_q)) & ir & ~set_mask;
    irr_n = ltim ? ir : irr_edge;
    // an ACK1 set beats a same-cycle EOI clear of the same bit
    isr_n = (isr & ~(eoi_clr | aeoi_clr)) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      irr <= '0;
      isr <= '0;
      ir_q <= '0;
      inta_q <= 1'b1;
      lowest_prio <= 3'd7;
      rotate_aeoi <= 1'b0;
      ack_lvl <= '0;
      ack_real <= 1'b0;
      int_out <= 1'b0;
      int_vec <= '0;
      vec_valid <= 1'b0;
      first_ack <= 1'b0;
      second_ack <= 1'b0;
    end else begin
      ir_q <= ir;
      inta_q <= inta_n;
      irr <= irr_n;
      isr <= isr_n;
      rotate_aeoi <= rot_new;
      vec_valid <= 1'b0;
      if (lp_we) lowest_prio <= lp_new;
      else if (done & aeoi & rotate_aeoi) lowest_prio <= ack_lvl;
      unique case (state)
        IDLE: begin
          int_out <= ack1 ? 1'b0 : pending;
          if (ack1) begin
            state <= ACK1;
            first_ack <= 1'b1;
            ack_real <= pending;
            ack_lvl <= pending ? win : SPURIOUS_LVL;
          end
        end
        ACK1: begin
          if (ack2) begin
            state <= ACK2;
            first_ack <= 1'b0;
            second_ack <= 1'b1;
            vec_valid <= 1'b1;
            int_vec <= ack_lvl;
          end
        end
        default: begin
          state <= IDLE;
          second_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
